// File: rtl/mem_bus_ctrl_if.sv
// Requester-side handshake bundle for mem_bus_ctrl: instruction fetch port
// (read-only) and load/store port (read/write).
interface mem_bus_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ready;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_ready;
    logic [DATA_WIDTH-1:0] ls_rdata;

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
        input  if_ready, if_rdata, ls_ready, ls_rdata
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
        output if_ready, if_rdata, ls_ready, ls_rdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Two-port (fetch + load/store) round-robin controller that sequences one
// access at a time onto a 16-bit memory with a shared tristate data bus.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_bus_ctrl_if.slave         req,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_load,
    output logic                  mem_out_en,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    localparam int unsigned        CNT_W    = 2;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_lat_check
        $error("mem_bus_ctrl: READ_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

    state_e                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic                  port_ls_q,  port_ls_d;
    logic                  last_ls_q,  last_ls_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
    logic                  if_ready_q;
    logic                  ls_ready_q;
    logic                  mem_load_q;
    logic                  mem_out_en_q;
    logic                  busy_q;
    logic                  grant_ls;

    // Next-state logic: arbitration, latching, read counter and data capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        port_ls_d  = port_ls_q;
        last_ls_d  = last_ls_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        grant_ls   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req.if_req || req.ls_req) begin
                    // On contention the port not granted last time wins
                    grant_ls  = req.ls_req && (!req.if_req || !last_ls_q);
                    port_ls_d = grant_ls;
                    last_ls_d = grant_ls;
                    addr_d    = grant_ls ? req.ls_addr : req.if_addr;
                    wdata_d   = req.ls_wdata;
                    cnt_d     = '0;
                    state_d   = (grant_ls && req.ls_we) ? WRITE : READ;
                end
            end
            WRITE: state_d = RESP;
            READ: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    if (port_ls_q) ls_rdata_d = mem_data;
                    else           if_rdata_d = mem_data;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            port_ls_q    <= 1'b0;
            last_ls_q    <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
            if_ready_q   <= 1'b0;
            ls_ready_q   <= 1'b0;
            mem_load_q   <= 1'b0;
            mem_out_en_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            port_ls_q    <= port_ls_d;
            last_ls_q    <= last_ls_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
            if_ready_q   <= (state_d == RESP) && !port_ls_d;
            ls_ready_q   <= (state_d == RESP) &&  port_ls_d;
            mem_load_q   <= (state_d == WRITE);
            mem_out_en_q <= (state_d == READ);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign req.if_ready = if_ready_q;
    assign req.if_rdata = if_rdata_q;
    assign req.ls_ready = ls_ready_q;
    assign req.ls_rdata = ls_rdata_q;
    assign busy         = busy_q;
    assign mem_address  = addr_q;
    assign mem_load     = mem_load_q;
    assign mem_out_en   = mem_out_en_q;

    // The bus is driven only while the write strobe is up
    assign mem_data = mem_load_q ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a scoreboard of expected ready pulses;
// a second instance covers READ_LATENCY=3.
module tb_mem_bus_ctrl;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] KEEP = 16'h5A5A;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    mem_bus_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    wire  [DW-1:0] mem_data1, mem_data2;
    logic [AW-1:0] mem_address1, mem_address2;
    logic          mem_load1, mem_load2, mem_out_en1, mem_out_en2, busy1, busy2;

    mem_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(bus1), .busy(busy1),
        .mem_address(mem_address1), .mem_load(mem_load1),
        .mem_out_en(mem_out_en1), .mem_data(mem_data1));

    mem_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut2 (
        .clk(clk), .reset(reset), .req(bus2), .busy(busy2),
        .mem_address(mem_address2), .mem_load(mem_load2),
        .mem_out_en(mem_out_en2), .mem_data(mem_data2));

    // Memory models; a keeper pattern stands in for a released bus
    logic [DW-1:0] mem1 [0:255];
    logic [DW-1:0] mem2 [0:255];
    logic          pre_we, pre_sel;
    logic [7:0]    pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we && !pre_sel) mem1[pre_addr] <= pre_data;
        else if (mem_load1)     mem1[mem_address1[7:0]] <= mem_data1;
    end
    always @(posedge clk) begin
        if (pre_we && pre_sel)  mem2[pre_addr] <= pre_data;
        else if (mem_load2)     mem2[mem_address2[7:0]] <= mem_data2;
    end
    assign mem_data1 = mem_out_en1 ? mem1[mem_address1[7:0]] : 'z;
    assign mem_data1 = (!mem_out_en1 && !mem_load1) ? KEEP : 'z;
    assign mem_data2 = mem_out_en2 ? mem2[mem_address2[7:0]] : 'z;
    assign mem_data2 = (!mem_out_en2 && !mem_load2) ? KEEP : 'z;

    typedef struct {
        logic          ls;
        logic          is_read;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    int   checks = 0;
    int   errors = 0;
    logic prev_if = 1'b0;
    logic prev_ls = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle bus rules plus scoreboard pop on every ready pulse of dut1
    task automatic monitor();
        exp_t e;
        chk("bus_excl", 32'({prev_if & bus1.if_ready, prev_ls & bus1.ls_ready,
                             bus1.if_ready & bus1.ls_ready, mem_load1 & mem_out_en1,
                             mem_load2 & mem_out_en2}), 32'd0);
        if (bus1.if_ready || bus1.ls_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_port", 32'(bus1.ls_ready), 32'(e.ls));
                if (e.is_read)
                    chk("sb_rdata", 32'(e.ls ? bus1.ls_rdata : bus1.if_rdata), 32'(e.rdata));
            end
        end
        prev_if = bus1.if_ready;
        prev_ls = bus1.ls_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic wait_ready(output logic gi, output logic gl);
        gi = 1'b0;
        gl = 1'b0;
        for (int n = 0; n < 20 && !(gi || gl); n++) begin
            tick();
            gi = bus1.if_ready;
            gl = bus1.ls_ready;
        end
        chk("ready_timeout", 32'(gi | gl), 32'd1);
    endtask

    task automatic preload(input logic sel, input logic [7:0] a, input logic [DW-1:0] d);
        pre_sel  = sel;
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic push(input logic ls, input logic rd, input logic [DW-1:0] d);
        exp_t e;
        e.ls = ls; e.is_read = rd; e.rdata = d;
        sb.push_back(e);
    endtask

    initial begin
        logic gi, gl;
        int   n_if, n_ls;
        reset = 1'b1;
        pre_we = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_data = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
        bus1.ls_addr = '0; bus1.ls_wdata = '0;
        bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.ls_req = 1'b0; bus2.ls_we = 1'b0;
        bus2.ls_addr = '0; bus2.ls_wdata = '0;

        // Reset state, with memory preload done while reset is held
        tick(); tick();
        chk("rst_outputs", 32'({busy1, mem_load1, mem_out_en1, bus1.if_ready, bus1.ls_ready}), 32'd0);
        chk("rst_mem_address", 32'(mem_address1), 32'd0);
        chk("rst_rdata", 32'({bus1.if_rdata, bus1.ls_rdata}), 32'd0);
        chk("rst_mem_data_released", 32'(mem_data1), 32'(KEEP));
        preload(1'b0, 8'h00, 16'h1234);
        preload(1'b0, 8'h20, 16'hA020);
        preload(1'b0, 8'h22, 16'hA022);
        preload(1'b0, 8'h30, 16'hC030);
        preload(1'b0, 8'h32, 16'hC032);
        preload(1'b1, 8'h10, 16'hBEEF);
        reset = 1'b0;
        tick(); tick();
        chk("idle_busy", 32'(busy1), 32'd0);

        // Store then load through the LS port
        bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 16'h0010; bus1.ls_wdata = 16'hBEEF;
        push(1'b1, 1'b0, '0);
        tick();
        chk("wr_c1_strobes", 32'({mem_load1, mem_out_en1, busy1, bus1.ls_ready}), 32'b1010);
        chk("wr_c1_address", 32'(mem_address1), 32'h0010);
        chk("wr_c1_data", 32'(mem_data1), 32'hBEEF);
        tick();
        chk("wr_c2_ready", 32'({bus1.ls_ready, mem_load1}), 32'b10);
        chk("wr_c2_data_released", 32'(mem_data1), 32'(KEEP));
        bus1.ls_req = 1'b0;
        tick();
        chk("wr_c3_idle", 32'({busy1, bus1.ls_ready}), 32'd0);
        chk("wr_mem_written", 32'(mem1[8'h10]), 32'hBEEF);

        bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 16'h0010;
        push(1'b1, 1'b1, 16'hBEEF);
        tick();
        chk("rd_c1_strobes", 32'({mem_out_en1, mem_load1, bus1.ls_ready}), 32'b100);
        tick();
        chk("rd_c2_ready", 32'({bus1.ls_ready, mem_out_en1}), 32'b10);
        bus1.ls_req = 1'b0;
        tick();

        // Fetch from a preloaded word; LS result untouched
        bus1.if_req = 1'b1; bus1.if_addr = 16'h0000;
        push(1'b0, 1'b1, 16'h1234);
        wait_ready(gi, gl);
        chk("fetch_ls_rdata_kept", 32'(bus1.ls_rdata), 32'hBEEF);
        bus1.if_req = 1'b0;
        tick();

        // Continuous contention: LS, IF, LS, IF
        bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 16'h0020;
        bus1.if_req = 1'b1; bus1.if_addr = 16'h0030;
        push(1'b1, 1'b1, 16'hA020);
        push(1'b0, 1'b1, 16'hC030);
        push(1'b1, 1'b1, 16'hA022);
        push(1'b0, 1'b1, 16'hC032);
        n_if = 0; n_ls = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(gi, gl);
            if (gl) begin
                n_ls++;
                bus1.ls_addr = 16'h0022;
                if (n_ls == 2) bus1.ls_req = 1'b0;
            end
            if (gi) begin
                n_if++;
                bus1.if_addr = 16'h0032;
                if (n_if == 2) bus1.if_req = 1'b0;
            end
        end
        tick();
        chk("rr_sb_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a read drops the access
        bus1.if_req = 1'b1; bus1.if_addr = 16'h0030;
        tick();
        chk("rst_mid_in_read", 32'(mem_out_en1), 32'd1);
        reset = 1'b1;
        bus1.if_req = 1'b0;
        tick();
        chk("rst_mid_strobes", 32'({mem_out_en1, mem_load1, busy1, bus1.if_ready}), 32'd0);
        chk("rst_mid_rdata_cleared", 32'(bus1.if_rdata), 32'd0);
        chk("rst_mid_data_released", 32'(mem_data1), 32'(KEEP));
        reset = 1'b0;
        tick(); tick();
        chk("rst_mid_no_ready", 32'({bus1.if_ready, bus1.ls_ready, busy1}), 32'd0);
        bus1.if_req = 1'b1; bus1.if_addr = 16'h0000;
        push(1'b0, 1'b1, 16'h1234);
        wait_ready(gi, gl);
        bus1.if_req = 1'b0;
        tick();

        // READ_LATENCY=3 instance
        bus2.ls_req = 1'b1; bus2.ls_we = 1'b0; bus2.ls_addr = 16'h0010;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("lat3_read_cycle", 32'({mem_out_en2, bus2.ls_ready, busy2}), 32'b101);
        end
        tick();
        chk("lat3_ready", 32'({bus2.ls_ready, bus2.if_ready, mem_out_en2}), 32'b100);
        chk("lat3_rdata", 32'(bus2.ls_rdata), 32'hBEEF);
        bus2.ls_req = 1'b0;
        tick();
        chk("lat3_done", 32'({bus2.ls_ready, busy2}), 32'd0);
        chk("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory bus controller that sits directly upstream of the 16-bit `memory` block and owns its address, load, out_en and shared data bus. It accepts two requester ports: instruction fetch (read-only) and load/store (read/write). It arbitrates between them and sequences one memory access at a time. Each access completes with a registered one-cycle ready pulse back to the winning requester.

Parameters:
ADDR_WIDTH, 16, width of all address ports
DATA_WIDTH, 16, width of all data ports and of mem_data
READ_LATENCY, 1, cycles mem_out_en is held before read data is sampled; legal range 1..4, any other value is an elaboration error

Ports:
clk  input  1  system clock; everything is on the rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; level, held until if_ready
if_addr  input  ADDR_WIDTH  fetch address
if_ready  output  1  one-cycle pulse; if_rdata valid in the same cycle
if_rdata  output  DATA_WIDTH  fetched word, held until the next fetch completes
ls_req  input  1  load/store request; level, held until ls_ready
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR_WIDTH  load/store address
ls_wdata  input  DATA_WIDTH  store data
ls_ready  output  1  one-cycle completion pulse
ls_rdata  output  DATA_WIDTH  load result, held until the next load completes
busy  output  1  high in any state other than IDLE
mem_address  output  ADDR_WIDTH  to memory address
mem_load  output  1  to memory load (write strobe)
mem_out_en  output  1  to memory out_en
mem_data  inout  DATA_WIDTH  shared data bus to memory data_in/data_out

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - All outputs 0: if_ready, ls_ready, busy, mem_load, mem_out_en, mem_address, if_rdata, ls_rdata.
  - mem_data is high-Z.
  - FSM is in IDLE; last_grant = IF.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - Samples if_req and ls_req.
  - If only one is pending, that one is granted.
  - If both are pending, the port not granted last time wins (round-robin), so the first contention after reset goes to LS.
  - On grant, the controller latches address, we (forced 0 for IF), wdata and the port id, and updates last_grant.
  - Next state is WRITE if we=1, else READ.
- WRITE (exactly 1 cycle):
  - mem_load=1, mem_address=latched address, mem_data driven with latched wdata.
  - Next state is RESP.
- READ (READ_LATENCY cycles, counted by an internal counter):
  - mem_out_en=1, mem_address=latched address, mem_data released (Z).
  - mem_data is captured into the granted port's rdata register at the clock edge ending the last READ cycle.
  - Next state is RESP.
- RESP (1 cycle):
  - The granted port's ready is 1; the other port's ready stays 0.
  - mem_load=0 and mem_out_en=0.
  - Requests are ignored in this cycle. Requesters update req on the edge where they sample ready, so a request seen in the following IDLE is a new one.
  - Next state is IDLE.
- Latency, with the accept cycle numbered 0:
  - Write: ready in cycle 2.
  - Read: ready in cycle READ_LATENCY+1.
  - Back-to-back accesses start one IDLE cycle after RESP.
- Bus rules:
  - mem_load and mem_out_en are never high in the same cycle.
  - mem_data is driven only in WRITE; it is Z in every other state, including during reset.
  - mem_address holds its last value outside WRITE/READ.
- Request inputs that change while the FSM is not in IDLE have no effect; the latched copies are used.
- Reset mid-operation:
  - The FSM returns to IDLE at the reset edge and the pending access is dropped; no ready is issued.
  - mem_load, mem_out_en and the mem_data drive all deassert in the first cycle after the edge.
  - rdata registers are cleared to 0.
- busy = (state != IDLE).
- Address and data pass through with no arithmetic; no width conversion.

Test Plan:
1. Hold reset 2 cycles -> every output is 0 and mem_data is Z; after release with no requests, busy stays 0.
2. Store ls_addr=0x0010, ls_wdata=0xBEEF -> mem_load=1 only in cycle 1 with mem_address=0x0010 and mem_data=0xBEEF; ls_ready pulses in cycle 2. Then load 0x0010 -> mem_out_en in cycle 1, ls_rdata=0xBEEF with ls_ready in cycle 2.
3. Preload memory[0x0000]=0x1234; fetch if_addr=0x0000 -> if_ready pulse with if_rdata=0x1234; ls_ready stays 0; ls_rdata unchanged.
4. Hold if_req and ls_req continuously with distinct addresses -> grant order LS, IF, LS, IF; each ready pulse lasts exactly 1 cycle; the two readys are never high together.
5. Assert reset during a READ cycle -> no ready pulse; mem_out_en=0 the cycle after; busy=0. A subsequent fetch of 0x0000 returns 0x1234 normally.
6. READ_LATENCY=3, load from 0x0010 -> mem_out_en high in cycles 1-3; ls_ready and ls_rdata=0xBEEF in cycle 4.
